fp_adder_driver: RTL and testbench

FP_ADDER_DRIVER -- requirements
Module: fp_adder_driver

---
 rtl/fp_adder_driver.sv | 114 +++++++++++
 tb/tb_fp_adder_driver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_driver.sv
// Drives an external strobed FP adder to sum a vector of words one element at a time.
// The accumulator and count are returned together, with an error flag if the adder stops responding.
module fp_adder_driver #(
  parameter int N       = 32,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     data_in,
  input  logic             data_in_stb,
  input  logic             data_in_last,
  output logic             data_in_ack,
  output logic [N-1:0]     adder_a,
  output logic             adder_a_stb,
  output logic [N-1:0]     adder_b,
  output logic             adder_b_stb,
  input  logic [N-1:0]     adder_z,
  input  logic             adder_z_stb,
  output logic [N-1:0]     sum_out,
  output logic             sum_out_stb,
  input  logic             sum_out_ack,
  output logic [CNT_W-1:0] count_out,
  output logic             error
);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, DONE} state_t;
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [N-1:0]     acc;
  logic [N-1:0]     operand;
  logic             last;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [WW-1:0]    wait_cnt;

  assign count_inc = (&count) ? count : count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      operand     <= '0;
      last        <= 1'b0;
      count       <= '0;
      wait_cnt    <= '0;
      data_in_ack <= 1'b0;
      adder_a     <= '0;
      adder_a_stb <= 1'b0;
      adder_b     <= '0;
      adder_b_stb <= 1'b0;
      sum_out     <= '0;
      sum_out_stb <= 1'b0;
      count_out   <= '0;
      error       <= 1'b0;
    end else begin
      data_in_ack <= 1'b0;
      adder_a_stb <= 1'b0;
      adder_b_stb <= 1'b0;
      case (state)
        IDLE: if (data_in_stb) begin
          operand     <= data_in;
          last        <= data_in_last;
          data_in_ack <= 1'b1;
          state       <= SEND_A;
        end
        SEND_A: begin
          adder_a     <= acc;
          adder_a_stb <= 1'b1;
          state       <= SEND_B;
        end
        SEND_B: begin
          adder_b     <= operand;
          adder_b_stb <= 1'b1;
          wait_cnt    <= '0;
          state       <= WAIT_Z;
        end
        WAIT_Z: begin
          // A result arriving on the last timeout cycle still wins over the timeout.
          if (adder_z_stb) begin
            acc   <= adder_z;
            count <= count_inc;
            if (last) begin
              sum_out     <= adder_z;
              count_out   <= count_inc;
              sum_out_stb <= 1'b1;
              state       <= DONE;
            end else begin
              state <= IDLE;
            end
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            error       <= 1'b1;
            sum_out     <= acc;
            count_out   <= count;
            sum_out_stb <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: if (sum_out_ack) begin
          sum_out_stb <= 1'b0;
          acc         <= '0;
          count       <= '0;
          error       <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder_driver.sv
// Directed bench for fp_adder_driver with a lookup-table strobed adder model.
// Expected sums are hand-computed single-precision constants.
module tb_fp_adder_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        data_in_stb, data_in_last, data_in_ack;
  logic [31:0] adder_a, adder_b, adder_z;
  logic        adder_a_stb, adder_b_stb, adder_z_stb;
  logic [31:0] sum_out;
  logic        sum_out_stb, sum_out_ack;
  logic [7:0]  count_out;
  logic        error;

  fp_adder_driver #(.N(32), .CNT_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_stb(data_in_stb), .data_in_last(data_in_last),
    .data_in_ack(data_in_ack),
    .adder_a(adder_a), .adder_a_stb(adder_a_stb),
    .adder_b(adder_b), .adder_b_stb(adder_b_stb),
    .adder_z(adder_z), .adder_z_stb(adder_z_stb),
    .sum_out(sum_out), .sum_out_stb(sum_out_stb), .sum_out_ack(sum_out_ack),
    .count_out(count_out), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hand-computed IEEE-754 single-precision sums for the operand pairs used here.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h00000000_3F800000: return 32'h3F800000;
      64'h3F800000_40000000: return 32'h40400000;
      64'h40400000_3F000000: return 32'h40600000;
      64'h00000000_C0400000: return 32'hC0400000;
      64'h00000000_40000000: return 32'h40000000;
      64'h00000000_3F000000: return 32'h3F000000;
      64'h3F800000_3F800000: return 32'h40000000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  // Adder model: owned state below is written only by this process.
  logic        adder_on = 1'b1;
  int          lat = 2;
  int          inj_req = 0;
  int          inj_ack = 0;
  logic [31:0] a_hold, b_hold;
  logic [31:0] a_arr [0:63];
  int          a_cnt = 0;
  int          cyc = 0;
  int          last_z_cyc = -100;
  int          viol_ab = 0;
  int          viol_z = 0;
  logic        pend = 1'b0;
  int          wait_n = 0;

  initial begin
    adder_z     = '0;
    adder_z_stb = 1'b0;
  end

  always @(negedge clk) begin
    cyc++;
    if (adder_a_stb && adder_b_stb) viol_ab++;
    if (adder_a_stb && (cyc - last_z_cyc) <= 1) viol_z++;
    if (adder_a_stb) begin
      a_hold = adder_a;
      if (a_cnt < 64) a_arr[a_cnt] = adder_a;
      a_cnt++;
    end
    adder_z_stb = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else if (inj_req != inj_ack) begin
      inj_ack     = inj_req;
      adder_z_stb = 1'b1;
      adder_z     = 32'h3F800000;
      last_z_cyc  = cyc;
    end else if (pend) begin
      if (wait_n == 0) begin
        adder_z_stb = 1'b1;
        adder_z     = fadd(a_hold, b_hold);
        pend        = 1'b0;
        last_z_cyc  = cyc;
      end else begin
        wait_n--;
      end
    end
    if (adder_b_stb && adder_on && !rst) begin
      b_hold = adder_b;
      pend   = 1'b1;
      wait_n = lat;
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    logic ok = 1'b0;
    @(negedge clk);
    data_in = d; data_in_last = l; data_in_stb = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (data_in_ack) begin ok = 1'b1; break; end
    end
    data_in_stb = 1'b0;
    chk("in_ack_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_sum();
    logic ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sum_out_stb) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("sum_stb_seen", 32'(ok), 32'd1);
  endtask

  task automatic ack_sum();
    sum_out_ack = 1'b1;
    @(negedge clk);
    sum_out_ack = 1'b0;
    chk("sum_stb_clr", 32'(sum_out_stb), 32'd0);
  endtask

  task automatic chk_sum(input string tag, input logic [31:0] s, input logic [7:0] c, input logic e);
    chk({tag, "_sum"}, sum_out, s);
    chk({tag, "_cnt"}, 32'(count_out), 32'(c));
    chk({tag, "_err"}, 32'(error), 32'(e));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ack"}, 32'(data_in_ack), 32'd0);
    chk({tag, "_a"}, adder_a, 32'd0);
    chk({tag, "_a_stb"}, 32'(adder_a_stb), 32'd0);
    chk({tag, "_b"}, adder_b, 32'd0);
    chk({tag, "_b_stb"}, 32'(adder_b_stb), 32'd0);
    chk({tag, "_sum_stb"}, 32'(sum_out_stb), 32'd0);
    chk_sum(tag, 32'd0, 8'd0, 1'b0);
  endtask

  initial begin
    int base;
    int k;
    logic ok;
    rst = 1'b1; data_in = '0; data_in_stb = 1'b0; data_in_last = 1'b0; sum_out_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;

    // Three-element vector: 1.0 + 2.0 + 0.5 = 3.5
    base = a_cnt;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h3F000000, 1'b1);
    wait_sum();
    chk_sum("vec3", 32'h40600000, 8'd3, 1'b0);
    chk("vec3_a0", a_arr[base],     32'h00000000);
    chk("vec3_a1", a_arr[base + 1], 32'h3F800000);
    chk("vec3_a2", a_arr[base + 2], 32'h40400000);
    ack_sum();

    // Single element -3.0, then hold DONE for 10 cycles with a new element pending
    base = a_cnt;
    send(32'hC0400000, 1'b1);
    wait_sum();
    chk_sum("single", 32'hC0400000, 8'd1, 1'b0);
    chk("single_a", a_arr[base], 32'h00000000);
    chk("single_b_hold", adder_b, 32'hC0400000);
    data_in = 32'h40000000; data_in_last = 1'b1; data_in_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_in_ack", 32'(data_in_ack), 32'd0);
      chk("hold_stb", 32'(sum_out_stb), 32'd1);
      chk_sum("hold", 32'hC0400000, 8'd1, 1'b0);
    end
    sum_out_ack = 1'b1;
    @(negedge clk);
    sum_out_ack = 1'b0;
    chk("hold_ack_stb", 32'(sum_out_stb), 32'd0);
    chk("hold_ack_in_ack", 32'(data_in_ack), 32'd0);
    @(negedge clk);
    chk("hold_accept", 32'(data_in_ack), 32'd1);
    data_in_stb = 1'b0;
    wait_sum();
    chk_sum("after_hold", 32'h40000000, 8'd1, 1'b0);
    ack_sum();

    // Timeout: first element summed, adder then goes silent
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    adder_on = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (adder_b_stb) begin ok = 1'b1; break; end
    end
    chk("to_b_seen", 32'(ok), 32'd1);
    k = 0;
    while (!sum_out_stb && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("to_cycles", 32'(k), 32'd64);
    chk_sum("to", 32'h3F800000, 8'd1, 1'b1);
    ack_sum();
    chk("to_err_clr", 32'(error), 32'd0);
    adder_on = 1'b1;
    send(32'h3F000000, 1'b1);
    wait_sum();
    chk_sum("post_to", 32'h3F000000, 8'd1, 1'b0);
    ack_sum();

    // Reset during WAIT_Z, followed by a stray adder result
    adder_on = 1'b0;
    send(32'h3F800000, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (adder_b_stb) begin ok = 1'b1; break; end
    end
    chk("mid_b_seen", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("mid_rst");
    inj_req++;
    repeat (4) @(negedge clk);
    chk("stray_sum_stb", 32'(sum_out_stb), 32'd0);
    chk("stray_a_stb", 32'(adder_a_stb), 32'd0);
    adder_on = 1'b1;
    send(32'h40000000, 1'b1);
    wait_sum();
    chk_sum("post_rst", 32'h40000000, 8'd1, 1'b0);
    ack_sum();

    // Fastest adder: result one cycle after the second operand
    lat = 0;
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b1);
    wait_sum();
    chk_sum("fast", 32'h40000000, 8'd2, 1'b0);
    ack_sum();
    chk("viol_ab", 32'(viol_ab), 32'd0);
    chk("viol_z", 32'(viol_z), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
